// File: rtl/hazard_history.sv
// Destination-register history for EX/MEM/WB (prev1..prev3), load-use bubble
// insertion, decode hold and stall watchdog. Optional counters: HAZARD_PERF_COUNTER_EN.
module hazard_history #(
  parameter int STALL_LIMIT = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_reg_write,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_mem_read,
  input  logic             skip_instr,
  input  logic             stall_in,
  input  logic             flush,
  output logic             prev1_write,
  output logic             prev2_write,
  output logic             prev3_write,
  output logic [4:0]       prev1_write_addr,
  output logic [4:0]       prev2_write_addr,
  output logic [4:0]       prev3_write_addr,
  output logic             prev1_mem,
  output logic             prev2_mem,
  output logic             prev3_mem,
  output logic             id_stall,
  output logic             issue,
  output logic             stall_err,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic       write;
    logic [4:0] addr;
    logic       mem;
  } entry_t;

  localparam int WD_W = $clog2(STALL_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_LIMIT);

  entry_t            incoming;
  entry_t            stage1, stage2, stage3;
  logic [WD_W-1:0]   wd_count;
  logic [WD_W-1:0]   wd_next;

  assign issue    = id_valid && !skip_instr && !flush && !stall_in;
  assign id_stall = skip_instr || stall_in;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    incoming = '0;
    if (issue) begin
      incoming.write = id_reg_write && (id_rd_addr != 5'd0);
      incoming.addr  = id_rd_addr;
      incoming.mem   = id_reg_write && id_mem_read;
    end
  end

  // Watchdog only moves on unfrozen cycles; it saturates at the limit so it never wraps.
  always_comb begin
    wd_next = wd_count;
    if (!stall_in) begin
      if (!skip_instr)
        wd_next = '0;
      else if (wd_count != WD_MAX)
        wd_next = wd_count + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so stages shift on old values.
    if (!rst_n) begin
      stage1    <= '0;
      stage2    <= '0;
      stage3    <= '0;
      wd_count  <= '0;
      stall_err <= 1'b0;
    end else begin
      if (!stall_in) begin
        stage3 <= stage2;
        stage2 <= stage1;
        stage1 <= incoming;
      end
      wd_count <= wd_next;
      if (wd_next == WD_MAX)
        stall_err <= 1'b1;
    end
  end

  assign prev1_write      = stage1.write;
  assign prev1_write_addr = stage1.addr;
  assign prev1_mem        = stage1.mem;
  assign prev2_write      = stage2.write;
  assign prev2_write_addr = stage2.addr;
  assign prev2_mem        = stage2.mem;
  assign prev3_write      = stage3.write;
  assign prev3_write_addr = stage3.addr;
  assign prev3_mem        = stage3.mem;

`ifdef HAZARD_PERF_COUNTER_EN
  // A simultaneous flush and skip is accounted as a flush only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
      flush_count  <= '0;
    end else if (!stall_in) begin
      if (skip_instr && !flush && (bubble_count != '1))
        bubble_count <= bubble_count + CNT_W'(1);
      if (flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`else
  assign bubble_count = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_history.sv
// Directed self-checking bench for hazard_history; stage values are compared
// as packed {write, addr[4:0], mem}.
module tb_hazard_history;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, id_reg_write, id_mem_read;
  logic [4:0]       id_rd_addr;
  logic             skip_instr, stall_in, flush;
  logic             prev1_write, prev2_write, prev3_write;
  logic [4:0]       prev1_write_addr, prev2_write_addr, prev3_write_addr;
  logic             prev1_mem, prev2_mem, prev3_mem;
  logic             id_stall, issue, stall_err;
  logic [CNT_W-1:0] bubble_count, flush_count;

  int checks = 0;
  int failures = 0;

  hazard_history #(.STALL_LIMIT(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_rd_addr(id_rd_addr),
    .id_mem_read(id_mem_read), .skip_instr(skip_instr), .stall_in(stall_in),
    .flush(flush),
    .prev1_write(prev1_write), .prev2_write(prev2_write), .prev3_write(prev3_write),
    .prev1_write_addr(prev1_write_addr), .prev2_write_addr(prev2_write_addr),
    .prev3_write_addr(prev3_write_addr),
    .prev1_mem(prev1_mem), .prev2_mem(prev2_mem), .prev3_mem(prev3_mem),
    .id_stall(id_stall), .issue(issue), .stall_err(stall_err),
    .bubble_count(bubble_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ent(input logic w, input logic [4:0] a, input logic m);
    return {w, a, m};
  endfunction

  task automatic chk_stages(input string tag, input logic [6:0] e1, input logic [6:0] e2,
                            input logic [6:0] e3);
    check({tag, ".p1"}, 32'({prev1_write, prev1_write_addr, prev1_mem}), 32'(e1));
    check({tag, ".p2"}, 32'({prev2_write, prev2_write_addr, prev2_mem}), 32'(e2));
    check({tag, ".p3"}, 32'({prev3_write, prev3_write_addr, prev3_mem}), 32'(e3));
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic mr,
                       input logic sk, input logic st, input logic fl);
    id_valid = v; id_reg_write = rw; id_rd_addr = rd; id_mem_read = mr;
    skip_instr = sk; stall_in = st; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected counter values depend on whether the optional counters are built.
  function automatic logic [31:0] cnt(input int n);
`ifdef HAZARD_PERF_COUNTER_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_stages("reset", 7'd0, 7'd0, 7'd0);
    check("reset.err", 32'(stall_err), 0);
    check("reset.bcnt", bubble_count, 0);
    check("reset.fcnt", flush_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x5, SUB x6, nop, ADDI x0
    drive(1, 1, 5'd5, 0, 0, 0, 0);
    check("add.issue", 32'(issue), 1);
    check("add.id_stall", 32'(id_stall), 0);
    tick();
    chk_stages("add", ent(1, 5, 0), 7'd0, 7'd0);
    drive(1, 1, 5'd6, 0, 0, 0, 0);
    tick();
    chk_stages("sub", ent(1, 6, 0), ent(1, 5, 0), 7'd0);
    drive(0, 0, 5'd0, 0, 0, 0, 0);
    tick();
    chk_stages("nop", 7'd0, ent(1, 6, 0), ent(1, 5, 0));
    drive(1, 1, 5'd0, 0, 0, 0, 0);
    tick();
    chk_stages("x0", ent(0, 0, 0), 7'd0, ent(1, 6, 0));

    // Load x7 followed by a dependent instruction
    drive(1, 1, 5'd7, 1, 0, 0, 0);
    tick();
    chk_stages("load", ent(1, 7, 1), 7'd0, 7'd0);
    drive(1, 1, 5'd8, 0, 1, 0, 0);
    check("lu.issue", 32'(issue), 0);
    check("lu.id_stall", 32'(id_stall), 1);
    tick();
    chk_stages("lu.bubble", 7'd0, ent(1, 7, 1), 7'd0);
    drive(1, 1, 5'd8, 0, 0, 0, 0);
    check("lu.reissue", 32'(issue), 1);
    tick();
    chk_stages("lu.dep", ent(1, 8, 0), 7'd0, ent(1, 7, 1));
    check("lu.bcnt", bubble_count, cnt(1));

    // Global freeze with a load in prev1 and a concurrent flush
    drive(1, 1, 5'd10, 1, 0, 0, 0);
    tick();
    chk_stages("ld10", ent(1, 10, 1), ent(1, 8, 0), 7'd0);
    drive(1, 1, 5'd11, 0, 0, 1, 1);
    check("frz.issue", 32'(issue), 0);
    check("frz.id_stall", 32'(id_stall), 1);
    for (int i = 0; i < 3; i++) tick();
    chk_stages("frz", ent(1, 10, 1), ent(1, 8, 0), 7'd0);
    check("frz.fcnt", flush_count, cnt(0));
    drive(1, 1, 5'd11, 0, 0, 0, 0);
    tick();
    chk_stages("rel1", ent(1, 11, 0), ent(1, 10, 1), ent(1, 8, 0));
    drive(0, 0, 5'd0, 0, 0, 0, 0);
    tick();
    chk_stages("rel2", 7'd0, ent(1, 11, 0), ent(1, 10, 1));

    // Flush of a valid x9 writer
    drive(1, 1, 5'd9, 0, 0, 0, 1);
    check("fl.issue", 32'(issue), 0);
    check("fl.id_stall", 32'(id_stall), 0);
    tick();
    chk_stages("fl", 7'd0, 7'd0, ent(1, 11, 0));
    check("fl.fcnt", flush_count, cnt(1));

    // Simultaneous flush and skip: counted as flush only
    drive(1, 1, 5'd9, 0, 1, 0, 1);
    tick();
    check("flsk.p1", 32'({prev1_write, prev1_write_addr, prev1_mem}), 0);
    check("flsk.fcnt", flush_count, cnt(2));
    check("flsk.bcnt", bubble_count, cnt(1));
    drive(0, 0, 5'd0, 0, 0, 0, 0);
    tick();
    check("flsk.err", 32'(stall_err), 0);

    // Watchdog: frozen cycle in between neither counts nor clears
    drive(1, 1, 5'd3, 0, 1, 0, 0);
    tick();
    check("wd.1", 32'(stall_err), 0);
    drive(1, 1, 5'd3, 0, 1, 1, 0);
    tick();
    check("wd.hold", 32'(stall_err), 0);
    drive(1, 1, 5'd3, 0, 1, 0, 0);
    tick();
    check("wd.2", 32'(stall_err), 1);
    check("wd.bcnt", bubble_count, cnt(3));
    drive(0, 0, 5'd0, 0, 0, 0, 0);
    tick();
    check("wd.sticky", 32'(stall_err), 1);

    // Asynchronous reset mid-stream
    drive(1, 1, 5'd12, 1, 0, 0, 0);
    tick();
    drive(1, 1, 5'd13, 0, 0, 0, 0);
    tick();
    chk_stages("pre_rst", ent(1, 13, 0), ent(1, 12, 1), 7'd0);
    #1 rst_n = 1'b0;
    #1;
    chk_stages("arst", 7'd0, 7'd0, 7'd0);
    check("arst.err", 32'(stall_err), 0);
    check("arst.bcnt", bubble_count, 0);
    check("arst.fcnt", flush_count, 0);
    #1 rst_n = 1'b1;
    drive(1, 1, 5'd14, 0, 0, 0, 0);
    tick();
    chk_stages("post_rst", ent(1, 14, 0), 7'd0, 7'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
